// File: rtl/led_pwm_controller_if.sv
// led_pwm_controller_if: CPU native memory bus between master and LED controller
interface led_pwm_controller_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
  modport slave (input mem_valid, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/led_pwm_controller.sv
// led_pwm_controller: memory-mapped LED driver with per-channel 8-bit PWM dimming
module led_pwm_controller #(
  parameter int          NUM_CH         = 6,
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter logic [15:0] PRESCALE_RESET = 16'd105
) (
  input  logic                       clk,
  input  logic                       reset,
  led_pwm_controller_if.slave        bus,
  output logic [NUM_CH-1:0]          led
);
  logic [NUM_CH-1:0] out_r, mode_r, pwm, on;
  logic [15:0]       prescale, pre_cnt;
  logic [7:0]        phase;
  logic [7:0]        duty [NUM_CH];
  logic [5:0]        off;
  logic              accept, wr, ps_wr, tick;
  logic [31:0]       rd;
  logic              unused;
  assign off    = bus.mem_addr[7:2];
  assign accept = bus.mem_valid & ~bus.mem_ready;
  assign wr     = accept & (|bus.mem_wstrb);
  assign ps_wr  = wr & (off == 6'd2) & (|bus.mem_wstrb[1:0]);
  assign tick   = pre_cnt == prescale;
  assign on     = (mode_r & pwm) | (~mode_r & out_r);
  assign unused = ^{bus.mem_addr[31:8], bus.mem_addr[1:0], bus.mem_wdata[31:16]};
  // read mux: unmapped offsets and unimplemented bits read as zero
  always_comb begin
    rd = '0;
    if (off == 6'd0) rd[NUM_CH-1:0] = out_r;
    if (off == 6'd1) rd[NUM_CH-1:0] = mode_r;
    if (off == 6'd2) rd[15:0] = prescale;
    if (off == 6'd3) rd[7:0] = phase;
    for (int i = 0; i < NUM_CH; i++)
      if (off == 6'(4 + i)) rd[7:0] = duty[i];
  end
  // per-channel PWM compare against the shared phase
  always_comb begin
    pwm = '0;
    for (int i = 0; i < NUM_CH; i++)
      pwm[i] = phase < duty[i];
  end
  // bus handshake, read capture and byte-strobed register writes
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      out_r         <= '0;
      mode_r        <= '0;
      prescale      <= PRESCALE_RESET;
      for (int i = 0; i < NUM_CH; i++)
        duty[i] <= '0;
    end else begin
      bus.mem_ready <= accept;
      if (accept) bus.mem_rdata <= rd;
      if (wr && off == 6'd0 && bus.mem_wstrb[0]) out_r <= bus.mem_wdata[NUM_CH-1:0];
      if (wr && off == 6'd1 && bus.mem_wstrb[0]) mode_r <= bus.mem_wdata[NUM_CH-1:0];
      if (wr && off == 6'd2 && bus.mem_wstrb[0]) prescale[7:0] <= bus.mem_wdata[7:0];
      if (wr && off == 6'd2 && bus.mem_wstrb[1]) prescale[15:8] <= bus.mem_wdata[15:8];
      for (int i = 0; i < NUM_CH; i++)
        if (wr && off == 6'(4 + i) && bus.mem_wstrb[0]) duty[i] <= bus.mem_wdata[7:0];
    end
  end
  // prescaler and phase counter; a PRESCALE write restarts both
  always_ff @(posedge clk) begin
    if (reset || ps_wr) begin
      pre_cnt <= '0;
      phase   <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
      if (tick) phase <= phase + 8'd1;
    end
  end
  // registered pin driver with polarity applied
  always_ff @(posedge clk)
    led <= reset ? {NUM_CH{ACTIVE_LOW}} : on ^ {NUM_CH{ACTIVE_LOW}};
endmodule

// File: tb/tb_led_pwm_controller.sv
// tb_led_pwm_controller: table, hand-written and random checks against a behavioural model
module tb_led_pwm_controller;
  localparam int NUM_CH = 6;
  logic clk = 1'b0;
  logic reset;
  logic [NUM_CH-1:0] led;
  longint cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  led_pwm_controller_if bif ();
  led_pwm_controller #(.NUM_CH(NUM_CH), .ACTIVE_LOW(1'b1), .PRESCALE_RESET(16'd105)) dut (
    .clk(clk), .reset(reset), .bus(bif), .led(led));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  logic [NUM_CH-1:0] m_out, m_mode;
  logic [15:0] m_ps;
  logic [7:0] m_duty [NUM_CH];
  longint clr_cyc;

  task automatic model_reset();
    m_out = '0;
    m_mode = '0;
    m_ps = 16'd105;
    for (int i = 0; i < NUM_CH; i++) m_duty[i] = '0;
    clr_cyc = cyc;
  endtask

  function automatic logic [7:0] phase_at(longint c);
    return 8'(((c - clr_cyc) / (longint'(m_ps) + 1)) % 256);
  endfunction

  function automatic logic [NUM_CH-1:0] model_led(longint c);
    logic [NUM_CH-1:0] o;
    for (int i = 0; i < NUM_CH; i++)
      o[i] = m_mode[i] ? (phase_at(c) < m_duty[i]) : m_out[i];
    return ~o;
  endfunction

  function automatic logic [31:0] model_read(logic [7:0] a);
    int k;
    k = int'(a[7:2]);
    if (k == 0) return 32'(m_out);
    if (k == 1) return 32'(m_mode);
    if (k == 2) return 32'(m_ps);
    if (k == 3) return 32'(phase_at(cyc));
    if (k >= 4 && k < 4 + NUM_CH) return 32'(m_duty[k-4]);
    return 32'h0;
  endfunction

  task automatic model_write(logic [7:0] a, logic [31:0] d, logic [3:0] s);
    int k;
    k = int'(a[7:2]);
    if (k == 0 && s[0]) m_out = d[NUM_CH-1:0];
    if (k == 1 && s[0]) m_mode = d[NUM_CH-1:0];
    if (k == 2 && s[0]) m_ps[7:0] = d[7:0];
    if (k == 2 && s[1]) m_ps[15:8] = d[15:8];
    if (k == 2 && (s[0] || s[1])) clr_cyc = cyc;
    if (k >= 4 && k < 4 + NUM_CH && s[0]) m_duty[k-4] = d[7:0];
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] q);
    int n;
    logic [31:0] e;
    e = model_read(a);
    bif.mem_addr = {24'($urandom), a};
    bif.mem_wdata = d;
    bif.mem_wstrb = s;
    bif.mem_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bif.mem_ready && n < 8);
    chk("latency", 32'(n), 32'd1);
    q = bif.mem_rdata;
    bif.mem_valid = 1'b0;
    bif.mem_wstrb = 4'h0;
    if (s == 4'h0) chk("rd_model", q, e);
    else model_write(a, d, s);
    @(negedge clk);
  endtask

  task automatic led_window(input int len, input string name, output int lows0);
    int bad;
    bad = 0;
    lows0 = 0;
    repeat (len) begin
      @(negedge clk);
      if (led !== model_led(cyc - 1)) bad++;
      if (!led[0]) lows0++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [17];

  initial begin
    logic [31:0] q;
    logic [5:0] pat;
    int lows, n;
    tbl[0]  = '{8'h08, 32'h0, 4'h0, 32'd105};
    tbl[1]  = '{8'h00, 32'h15, 4'hF, 32'h0};
    tbl[2]  = '{8'h00, 32'h0, 4'h0, 32'h15};
    tbl[3]  = '{8'h18, 32'hAABBCCDD, 4'h2, 32'h0};
    tbl[4]  = '{8'h18, 32'h0, 4'h0, 32'h0};
    tbl[5]  = '{8'h18, 32'hAABBCCDD, 4'h1, 32'h0};
    tbl[6]  = '{8'h18, 32'h0, 4'h0, 32'hDD};
    tbl[7]  = '{8'h28, 32'h0, 4'h0, 32'h0};
    tbl[8]  = '{8'h04, 32'hFFFFFFFF, 4'hF, 32'h0};
    tbl[9]  = '{8'h04, 32'h0, 4'h0, 32'h3F};
    tbl[10] = '{8'h0C, 32'hFFFFFFFF, 4'hF, 32'h0};
    tbl[11] = '{8'h00, 32'hFFFFFF00, 4'hE, 32'h0};
    tbl[12] = '{8'h00, 32'h0, 4'h0, 32'h15};
    tbl[13] = '{8'h28, 32'hFFFFFFFF, 4'hF, 32'h0};
    tbl[14] = '{8'h28, 32'h0, 4'h0, 32'h0};
    tbl[15] = '{8'h04, 32'h0, 4'hF, 32'h0};
    tbl[16] = '{8'h04, 32'h0, 4'h0, 32'h0};
    bif.mem_valid = 1'b0;
    bif.mem_addr = '0;
    bif.mem_wdata = '0;
    bif.mem_wstrb = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_led", 32'(led), 32'h3F);
    chk("reset_ready", 32'(bif.mem_ready), 32'h0);
    chk("reset_rdata", bif.mem_rdata, 32'h0);
    reset = 1'b0;
    model_reset();
    // OUT write reaches the pin two edges after accept
    bif.mem_addr = 32'h0;
    bif.mem_wdata = 32'h15;
    bif.mem_wstrb = 4'hF;
    bif.mem_valid = 1'b1;
    @(negedge clk);
    chk("out_ready", 32'(bif.mem_ready), 32'h1);
    chk("out_led_lag", 32'(led), 32'h3F);
    bif.mem_valid = 1'b0;
    bif.mem_wstrb = 4'h0;
    m_out = 6'h15;
    @(negedge clk);
    chk("out_ready_drop", 32'(bif.mem_ready), 32'h0);
    chk("out_led", 32'(led), 32'h2A);
    @(negedge clk);
    // register vectors
    for (int i = 0; i < 17; i++) begin
      xfer(tbl[i].a, tbl[i].d, tbl[i].s, q);
      if (tbl[i].s == 4'h0) chk($sformatf("tbl%0d", i), q, tbl[i].exp);
    end
    led_window(20, "led_static", lows);
    // PWM duty boundaries at PRESCALE = 0
    xfer(8'h08, 32'h0, 4'h3, q);
    xfer(8'h04, 32'h1, 4'hF, q);
    xfer(8'h10, 32'd64, 4'hF, q);
    led_window(256, "pwm64_model", lows);
    chk("pwm64_on", 32'(lows), 32'd64);
    xfer(8'h10, 32'd0, 4'hF, q);
    led_window(256, "pwm0_model", lows);
    chk("pwm0_on", 32'(lows), 32'd0);
    xfer(8'h10, 32'd255, 4'hF, q);
    led_window(256, "pwm255_model", lows);
    chk("pwm255_on", 32'(lows), 32'd255);
    // PRESCALE = 3: phase every 4 cycles, wrap, restart on rewrite
    xfer(8'h08, 32'd3, 4'h3, q);
    for (int j = 0; j < 4; j++) begin
      repeat (150 + $urandom_range(0, 7)) @(negedge clk);
      xfer(8'h0C, 32'h0, 4'h0, q);
    end
    n = 0;
    while (phase_at(cyc) != 8'd255 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    xfer(8'h0C, 32'h0, 4'h0, q);
    chk("phase_255", q, 32'd255);
    repeat (4) @(negedge clk);
    xfer(8'h0C, 32'h0, 4'h0, q);
    chk("phase_wrap", q, 32'd0);
    repeat (9) @(negedge clk);
    xfer(8'h08, 32'd3, 4'h1, q);
    xfer(8'h0C, 32'h0, 4'h0, q);
    chk("phase_clr", q, 32'd0);
    // back-to-back reads with valid held high
    bif.mem_addr = 32'h8;
    bif.mem_wstrb = 4'h0;
    bif.mem_valid = 1'b1;
    pat[5] = bif.mem_ready;
    for (int i = 4; i >= 0; i--) begin
      @(negedge clk);
      pat[i] = bif.mem_ready;
    end
    bif.mem_valid = 1'b0;
    chk("b2b_pattern", 32'(pat), 32'h15);
    chk("b2b_rdata", bif.mem_rdata, 32'd3);
    @(negedge clk);
    // reset in a request cycle drops ready and the write
    bif.mem_addr = 32'h0;
    bif.mem_wdata = 32'h3F;
    bif.mem_wstrb = 4'hF;
    bif.mem_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_no_ready", 32'(bif.mem_ready), 32'h0);
    bif.mem_valid = 1'b0;
    bif.mem_wstrb = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rst_led", 32'(led), 32'h3F);
    xfer(8'h00, 32'h0, 4'h0, q);
    chk("rst_out", q, 32'h0);
    xfer(8'h04, 32'h0, 4'h0, q);
    chk("rst_mode", q, 32'h0);
    xfer(8'h08, 32'h0, 4'h0, q);
    chk("rst_prescale", q, 32'd105);
    for (int i = 0; i < NUM_CH; i++) begin
      xfer(8'(8'h10 + 4 * i), 32'h0, 4'h0, q);
      chk($sformatf("rst_duty%0d", i), q, 32'h0);
    end
    // randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      logic [7:0] a;
      logic [31:0] d;
      logic [3:0] s;
      a = 8'(4 * $urandom_range(0, 11));
      d = $urandom;
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      if (a == 8'h08) d = 32'($urandom_range(0, 7));
      xfer(a, d, s, q);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    xfer(8'h08, 32'd1, 4'h3, q);
    led_window(600, "led_random", lows);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
